// File: rtl/muldiv_pkg.sv
// Shared types and constants for the EX-stage multiply/divide sequencer.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } md_op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } md_state_t;

    localparam int DIV_ITERS = 32;

    // Two's-complement magnitude; 0x80000000 maps to itself, which reads
    // correctly as an unsigned 2^31.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Pipeline <-> mul/div sequencer handshake and HI/LO result bus.
interface muldiv_ctrl_if;
    import muldiv_pkg::*;

    logic        start_i;
    md_op_t      op_i;
    logic [31:0] src_a_i;
    logic [31:0] src_b_i;
    logic        cancel_i;
    logic        stall_o;
    logic        ready_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    modport master (
        output start_i, op_i, src_a_i, src_b_i, cancel_i,
        input  stall_o, ready_o, hi_o, lo_o
    );

    modport slave (
        input  start_i, op_i, src_a_i, src_b_i, cancel_i,
        output stall_o, ready_o, hi_o, lo_o
    );

endinterface

// File: rtl/div_radix2.sv
// Unsigned radix-2 restoring divider, one quotient bit per clock.
// The load cycle already performs the first iteration, so after the load
// edge plus 31 more edges quot/rem hold the final 32-bit result.
module div_radix2 (
    input  logic        clk,
    input  logic        resetn,
    input  logic        load,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quot,
    output logic [31:0] rem
);

    logic [31:0] dvs_q;
    logic [31:0] r_in, q_in, d_in, r_nx, q_nx;
    logic [32:0] r_sh, r_sub;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        r_in  = load ? 32'd0    : rem;
        q_in  = load ? dividend : quot;
        d_in  = load ? divisor  : dvs_q;
        r_sh  = {r_in, q_in[31]};
        r_sub = r_sh - {1'b0, d_in};
        if (r_sub[32]) begin
            r_nx = r_sh[31:0];
            q_nx = {q_in[30:0], 1'b0};
        end else begin
            r_nx = r_sub[31:0];
            q_nx = {q_in[30:0], 1'b1};
        end
    end

    // Partial remainder/quotient registers; divisor captured on load.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            quot  <= '0;
            rem   <= '0;
            dvs_q <= '0;
        end else begin
            quot <= q_nx;
            rem  <= r_nx;
            if (load) dvs_q <= divisor;
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer: stalls the pipeline while
// busy and delivers HI/LO with a one-cycle ready pulse.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int MUL_LAT = 2
) (
    input  logic          clk,
    input  logic          resetn,
    muldiv_ctrl_if.slave  bus
);

    localparam int CNT_MAX = (MUL_LAT > DIV_ITERS) ? MUL_LAT : DIV_ITERS;
    localparam int CW      = $clog2(CNT_MAX + 1);

    md_state_t   state, state_nx;
    logic [CW-1:0] cnt;
    md_op_t      op_q;
    logic [31:0] a_q, b_q;
    logic        accept, capture;
    logic [31:0] div_a, div_b, quot, rem;
    logic [63:0] ext_a, ext_b, prod;
    logic [31:0] hi_nx, lo_nx;
    logic        neg_q, neg_r;

    assign accept = (state == S_IDLE) & bus.start_i & ~bus.cancel_i;

    // Divider is loaded straight from the bus on acceptance so its first
    // iteration overlaps the acceptance cycle.
    assign div_a = bus.op_i[0] ? bus.src_a_i : abs32(bus.src_a_i);
    assign div_b = bus.op_i[0] ? bus.src_b_i : abs32(bus.src_b_i);

    div_radix2 u_div (
        .clk      (clk),
        .resetn   (resetn),
        .load     (accept),
        .dividend (div_a),
        .divisor  (div_b),
        .quot     (quot),
        .rem      (rem)
    );

    // Result formation: product, sign-fixed quotient/remainder, or the
    // divide-by-zero pattern.
    always_comb begin
        ext_a = (op_q == OP_MULT) ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
        ext_b = (op_q == OP_MULT) ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
        prod  = ext_a * ext_b;
        neg_q = (op_q == OP_DIV) & (a_q[31] ^ b_q[31]);
        neg_r = (op_q == OP_DIV) & a_q[31];
        if (!op_q[1]) begin
            hi_nx = prod[63:32];
            lo_nx = prod[31:0];
        end else if (b_q == 32'd0) begin
            hi_nx = a_q;
            lo_nx = 32'hFFFF_FFFF;
        end else begin
            lo_nx = neg_q ? (~quot + 32'd1) : quot;
            hi_nx = neg_r ? (~rem + 32'd1)  : rem;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nx;
    end

    // Next state, stall/ready and result capture; cancel overrides all.
    always_comb begin
        state_nx    = state;
        bus.stall_o = 1'b0;
        bus.ready_o = 1'b0;
        capture     = 1'b0;
        case (state)
            S_IDLE: begin
                bus.stall_o = bus.start_i;
                if (bus.start_i) state_nx = bus.op_i[1] ? S_DIV : S_MUL;
            end
            S_MUL: begin
                bus.stall_o = 1'b1;
                if (cnt == CW'(MUL_LAT - 1)) begin
                    state_nx = S_DONE;
                    capture  = 1'b1;
                end
            end
            S_DIV: begin
                bus.stall_o = 1'b1;
                if (cnt == CW'(DIV_ITERS - 1)) begin
                    state_nx = S_DONE;
                    capture  = 1'b1;
                end
            end
            default: begin
                bus.ready_o = 1'b1;
                state_nx    = S_IDLE;
            end
        endcase
        if (bus.cancel_i) begin
            state_nx    = S_IDLE;
            bus.stall_o = 1'b0;
            capture     = 1'b0;
        end
    end

    // Busy-cycle counter, restarted on every state change.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                                  cnt <= '0;
        else if (state_nx != state)                   cnt <= '0;
        else if (state == S_MUL || state == S_DIV)    cnt <= cnt + 1'b1;
    end

    // Operand latch on acceptance; later bus changes are ignored.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_q <= OP_MULT;
            a_q  <= '0;
            b_q  <= '0;
        end else if (accept) begin
            op_q <= bus.op_i;
            a_q  <= bus.src_a_i;
            b_q  <= bus.src_b_i;
        end
    end

    // HI/LO registers, loaded only on entry to DONE.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus.hi_o <= '0;
            bus.lo_o <= '0;
        end else if (capture) begin
            bus.hi_o <= hi_nx;
            bus.lo_o <= lo_nx;
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: vector table plus cancel/reset sequences.
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    localparam int MUL_LAT = 2;
    localparam int LAT_M   = MUL_LAT + 1;
    localparam int LAT_D   = DIV_ITERS + 1;

    typedef struct {
        md_op_t      op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        string       name;
    } vec_t;

    logic clk = 1'b0;
    logic resetn;
    int   total = 0;
    int   bad   = 0;
    vec_t vecs[10];
    logic [31:0] last_hi, last_lo;

    muldiv_ctrl_if bus ();

    muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Drive inputs mid-cycle, then settle before the checks.
    task automatic drive(input logic s, input md_op_t o, input logic [31:0] a,
                         input logic [31:0] b, input logic c);
        @(negedge clk);
        bus.start_i  = s;
        bus.op_i     = o;
        bus.src_a_i  = a;
        bus.src_b_i  = b;
        bus.cancel_i = c;
        #1;
    endtask

    task automatic idle_no_ready(input int n, input string nm);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            drive(1'b0, OP_MULT, 32'd0, 32'd0, 1'b0);
            if (bus.ready_o !== 1'b0 || bus.stall_o !== 1'b0) seen = 1'b1;
        end
        chk(nm, {31'd0, seen}, 32'd0);
    endtask

    // Start is held through DONE with scrambled operands after acceptance.
    task automatic run_op(input vec_t v);
        drive(1'b1, v.op, v.a, v.b, 1'b0);
        chk($sformatf("%s stall c0", v.name), {31'd0, bus.stall_o}, 32'd1);
        chk($sformatf("%s ready c0", v.name), {31'd0, bus.ready_o}, 32'd0);
        for (int k = 1; k <= v.lat; k++) begin
            drive(1'b1, md_op_t'(2'($urandom_range(0, 3))), $urandom, $urandom, 1'b0);
            if (k < v.lat) begin
                chk($sformatf("%s stall c%0d", v.name, k), {31'd0, bus.stall_o}, 32'd1);
                chk($sformatf("%s ready c%0d", v.name, k), {31'd0, bus.ready_o}, 32'd0);
            end else begin
                chk($sformatf("%s ready c%0d", v.name, k), {31'd0, bus.ready_o}, 32'd1);
                chk($sformatf("%s stall c%0d", v.name, k), {31'd0, bus.stall_o}, 32'd0);
                chk($sformatf("%s hi", v.name), bus.hi_o, v.hi);
                chk($sformatf("%s lo", v.name), bus.lo_o, v.lo);
            end
        end
        drive(1'b0, OP_MULT, 32'd0, 32'd0, 1'b0);
        chk($sformatf("%s ready after", v.name), {31'd0, bus.ready_o}, 32'd0);
        chk($sformatf("%s lo hold", v.name), bus.lo_o, v.lo);
    endtask

    initial begin
        vecs[0] = '{OP_MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, LAT_M, "mult_neg"};
        vecs[1] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, LAT_M, "multu_max"};
        vecs[2] = '{OP_MULT,  32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000, LAT_M, "mult_ext"};
        vecs[3] = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, LAT_D, "div_m7_2"};
        vecs[4] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, LAT_D, "div_ovf"};
        vecs[5] = '{OP_DIVU,  32'd100,       32'd0,        32'h0000_0064, 32'hFFFF_FFFF, LAT_D, "divu_by0"};
        vecs[6] = '{OP_DIVU,  32'd100,       32'd7,        32'd2,         32'd14,        LAT_D, "divu_100_7"};
        vecs[7] = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, LAT_D, "div_7_m2"};
        vecs[8] = '{OP_DIV,   32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF, LAT_D, "div_by0"};
        vecs[9] = '{OP_DIVU,  32'hFFFF_FFFF, 32'd1,        32'd0,         32'hFFFF_FFFF, LAT_D, "divu_max_1"};

        resetn       = 1'b0;
        bus.start_i  = 1'b0;
        bus.op_i     = OP_MULT;
        bus.src_a_i  = '0;
        bus.src_b_i  = '0;
        bus.cancel_i = 1'b0;
        @(negedge clk);
        #1;
        chk("rst ready", {31'd0, bus.ready_o}, 32'd0);
        chk("rst stall", {31'd0, bus.stall_o}, 32'd0);
        chk("rst hi", bus.hi_o, 32'd0);
        chk("rst lo", bus.lo_o, 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Cancel wins over start while idle.
        drive(1'b1, OP_DIV, 32'd9, 32'd3, 1'b1);
        chk("cancel prio stall", {31'd0, bus.stall_o}, 32'd0);
        idle_no_ready(36, "cancel prio no ready");
        chk("cancel prio lo", bus.lo_o, 32'd0);

        for (int i = 0; i < 10; i++) run_op(vecs[i]);
        last_hi = vecs[9].hi;
        last_lo = vecs[9].lo;

        // DIV cancelled at cycle 10, MULTU issued the cycle after.
        drive(1'b1, OP_DIV, 32'd1000, 32'd3, 1'b0);
        for (int k = 1; k < 10; k++) drive(1'b1, OP_DIV, 32'd1000, 32'd3, 1'b0);
        chk("cancel c9 stall", {31'd0, bus.stall_o}, 32'd1);
        drive(1'b1, OP_DIV, 32'd1000, 32'd3, 1'b1);
        chk("cancel stall", {31'd0, bus.stall_o}, 32'd0);
        chk("cancel ready", {31'd0, bus.ready_o}, 32'd0);
        chk("cancel hi", bus.hi_o, last_hi);
        chk("cancel lo", bus.lo_o, last_lo);
        run_op('{OP_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, LAT_M, "multu_3_5"});
        idle_no_ready(30, "cancel no late ready");

        // Reset asserted at cycle 20 of a DIV with start low.
        drive(1'b1, OP_DIV, 32'd1000, 32'd3, 1'b0);
        for (int k = 1; k < 20; k++) drive(1'b0, OP_MULT, 32'd0, 32'd0, 1'b0);
        chk("rstmid c19 stall", {31'd0, bus.stall_o}, 32'd1);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("rstmid stall", {31'd0, bus.stall_o}, 32'd0);
        chk("rstmid ready", {31'd0, bus.ready_o}, 32'd0);
        chk("rstmid hi", bus.hi_o, 32'd0);
        chk("rstmid lo", bus.lo_o, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        idle_no_ready(40, "rstmid no ready");
        chk("rstmid lo hold", bus.lo_o, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Multi-cycle multiply/divide sequencer for the EX stage. It accepts MULT, MULTU, DIV and DIVU once the decoder has flagged a HI/LO write. It holds the pipeline with `stall_o` while the operation runs and presents the 64-bit result for the HI/LO registers with a one-cycle `ready_o` pulse. It also cancels cleanly on an exception flush.

## Interface
Parameters:
- `MUL_LAT`, default 2: cycles spent in state MUL (≥1).

Ports:
- `clk`: in, 1. Single clock; all state is updated on the rising edge.
- `resetn`: in, 1. Asynchronous, active-low reset.
- `start_i`: in, 1. EX holds a mul/div instruction. Held high by the pipeline while stalled.
- `op_i`: in, 2. Operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `src_a_i`: in, 32. rs value (dividend / multiplicand).
- `src_b_i`: in, 32. rt value (divisor / multiplier).
- `cancel_i`: in, 1. Exception flush; aborts any operation.
- `stall_o`: out, 1. Combinational request to freeze IF..EX.
- `ready_o`: out, 1. Result valid; high for exactly one cycle.
- `hi_o`: out, 32. HI result (product[63:32] / remainder).
- `lo_o`: out, 32. LO result (product[31:0] / quotient).

## Operation
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - `start_i & ~cancel_i` latches `op_i`, `src_a_i` and `src_b_i`.
  - Goes to MUL (op[1]=0) or DIV (op[1]=1).
- MUL:
  - Full 64-bit product; signed for MULT, unsigned for MULTU.
  - Counter runs `MUL_LAT` cycles, then DONE.
- DIV:
  - Radix-2 restoring divide on magnitudes: `|a|`, `|b|` for DIV, raw values for DIVU.
  - 32 iterations, one per cycle, then DONE.
- DIV sign fix (DIV only):
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - 0x80000000 / -1 gives lo=0x80000000, hi=0.
- Divide by zero (both ops): lo=0xFFFF_FFFF, hi=src_a. No sign fix. Takes the same 32-cycle latency.
- DONE:
  - `hi_o`/`lo_o` are registered on entry.
  - `ready_o`=1, `stall_o`=0; the pipeline advances this cycle.
  - `start_i` is ignored in DONE, since it is the same instruction.
  - Goes to IDLE next cycle.
- `stall_o` = (IDLE & `start_i` & ~`cancel_i`) | MUL | DIV.
- `ready_o` = (state==DONE).
- `hi_o`/`lo_o` hold the last result until the next DONE.
- `cancel_i` in any state:
  - Next state is IDLE.
  - `stall_o` drops in the same cycle.
  - No `ready_o`; `hi_o`/`lo_o` unchanged.
  - `cancel_i` has priority over `start_i`.
- `op_i`/`src` changes after acceptance are ignored.

## Timing
- Reset (`resetn`=0, asynchronous): state IDLE, counter 0, `hi_o`=`lo_o`=0, `ready_o`=0. `stall_o`=0 whenever `start_i`=0.
- Cycle numbering: acceptance is cycle 0.
- Multiply:
  - `stall_o` is high in cycles 0..`MUL_LAT`.
  - `ready_o` is high in cycle `MUL_LAT`+1. That is cycle 3 at the default.
- Divide:
  - `stall_o` is high in cycles 0..32.
  - `ready_o` and valid `hi_o`/`lo_o` appear in cycle 33.
- Back-to-back: a new `start_i` is accepted no earlier than the cycle after DONE, so the minimum issue interval is `MUL_LAT`+2 or 34 cycles.
- Reset mid-operation: immediate return to IDLE with outputs cleared; no `ready_o`.

## Structure
- `muldiv_pkg`: `md_op_t` (MULT/MULTU/DIV/DIVU encodings), `md_state_t`, `DIV_ITERS`=32.
- Sub-module `div_radix2`: unsigned iterative core.
  - Ports: `clk`, `resetn`, `load`, `dividend`, `divisor` → `quot`, `rem`.
  - One iteration per cycle.
  - Sign handling and the divide-by-zero override stay in `muldiv_ctrl`.

## Test plan
- MULT a=0xFFFFFFFD (-3), b=7 → `ready_o` at cycle 3, hi=0xFFFFFFFF, lo=0xFFFFFFEB; `stall_o` high cycles 0-2.
- MULTU a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=-7, b=2 → `ready_o` at cycle 33 only, lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/-1 → lo=0x80000000, hi=0.
- DIVU a=100, b=0 → cycle 33: lo=0xFFFFFFFF, hi=0x00000064.
- DIV started, `cancel_i` at cycle 10 → `stall_o` low that cycle, no `ready_o` ever, hi/lo unchanged. A new MULTU 3×5 started the next cycle gives lo=15 at +3.
- `resetn` low at cycle 20 of a DIV with `start_i` held low → state IDLE and hi=lo=0 immediately, no `ready_o`. `start_i` held high through DONE → exactly one `ready_o`, no re-issue.
